// File: rtl/umi_pkg.sv
// rtl/umi_pkg.sv - UMI command field layout, opcodes and checker state encoding
package umi_pkg;

    localparam int OPC_LSB  = 0;
    localparam int OPC_W    = 5;
    localparam int SIZE_LSB = 5;
    localparam int SIZE_W   = 3;
    localparam int LEN_LSB  = 8;
    localparam int LEN_W    = 8;

    localparam logic [OPC_W-1:0] UMI_REQ_RD   = 5'h01;
    localparam logic [OPC_W-1:0] UMI_REQ_WR   = 5'h03;
    localparam logic [OPC_W-1:0] UMI_REQ_RDMA = 5'h07;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/umi_checker_mask.sv
// rtl/umi_checker_mask.sv - expected-command to byte-enable mask and no-payload flag
module umi_checker_mask
    import umi_pkg::*;
#(
    parameter int DW = 512
) (
    input  logic [15:0]     cmd,
    output logic [DW/8-1:0] byte_mask,
    output logic            nocompare
);

    localparam int NB = DW / 8;

    logic [LEN_W-1:0]  len;
    logic [SIZE_W-1:0] size;
    logic [OPC_W-1:0]  opc;
    logic [16:0]       nbytes;
    logic [16:0]       nbytes_sat;

    assign len  = cmd[LEN_LSB +: LEN_W];
    assign size = cmd[SIZE_LSB +: SIZE_W];
    assign opc  = cmd[OPC_LSB +: OPC_W];

    // Byte count (LEN+1) << SIZE, clamped to the bus width; read opcodes carry no payload
    always_comb begin
        nbytes     = ({9'd0, len} + 17'd1) << size;
        nbytes_sat = (nbytes > 17'(NB)) ? 17'(NB) : nbytes;
        nocompare  = (opc == UMI_REQ_RD) || (opc == UMI_REQ_RDMA);
        byte_mask  = '0;
        for (int i = 0; i < NB; i++) begin
            byte_mask[i] = (17'(i) < nbytes_sat);
        end
    end

endmodule

// File: rtl/umi_checker.sv
// rtl/umi_checker.sv - UMI sink comparing received packets against an expected-packet memory
module umi_checker
    import umi_pkg::*;
#(
    parameter int CW    = 32,
    parameter int AW    = 64,
    parameter int DW    = 512,
    parameter int DEPTH = 1024
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         load_valid,
    output logic                         load_ready,
    input  logic [DW+2*AW+CW-1:0]        load_packet,
    input  logic                         go,
    input  logic [7:0]                   ready_pattern,
    input  logic                         umi_in_valid,
    input  logic [CW-1:0]                umi_in_cmd,
    input  logic [AW-1:0]                umi_in_dstaddr,
    input  logic [AW-1:0]                umi_in_srcaddr,
    input  logic [DW-1:0]                umi_in_data,
    output logic                         umi_in_ready,
    output logic                         done,
    output logic                         error,
    output logic [31:0]                  pass_count,
    output logic [31:0]                  fail_count,
    output logic [$clog2(DEPTH)-1:0]     fail_index
);

    localparam int PW  = $clog2(DEPTH);
    localparam int PKW = DW + 2*AW + CW;
    localparam logic [PW:0] PTR_ONE   = (PW+1)'(1);
    localparam logic [PW:0] PTR_DEPTH = (PW+1)'(DEPTH);

    logic [PKW-1:0] mem [DEPTH];

    state_t         state_q, state_d;
    logic [PW:0]    wptr_q, wptr_d;
    logic [PW:0]    rptr_q, rptr_d;
    logic [7:0]     pat_q, pat_d;
    logic [31:0]    pass_q, pass_d;
    logic [31:0]    fail_q, fail_d;
    logic [PW-1:0]  fidx_q, fidx_d;
    logic           err_q, err_d;

    logic [PKW-1:0] exp_pkt;
    logic [CW-1:0]  exp_cmd;
    logic [AW-1:0]  exp_dst;
    logic [AW-1:0]  exp_src;
    logic [DW-1:0]  exp_data;
    logic [DW/8-1:0] byte_mask;
    logic [DW-1:0]  bit_mask;
    logic           nocompare;
    logic           load_write;
    logic           hs;
    logic           match;

    assign exp_pkt  = mem[rptr_q[PW-1:0]];
    assign exp_cmd  = exp_pkt[CW-1:0];
    assign exp_dst  = exp_pkt[CW +: AW];
    assign exp_src  = exp_pkt[CW+AW +: AW];
    assign exp_data = exp_pkt[CW+2*AW +: DW];

    umi_checker_mask #(.DW(DW)) u_mask (
        .cmd       (exp_cmd[15:0]),
        .byte_mask (byte_mask),
        .nocompare (nocompare)
    );

    assign load_ready = (state_q == ST_IDLE) && (wptr_q != PTR_DEPTH);
    assign load_write = load_valid && load_ready;
    assign hs         = umi_in_valid && umi_in_ready;

    assign done       = (state_q == ST_DONE);
    assign error      = err_q;
    assign pass_count = pass_q;
    assign fail_count = fail_q;
    assign fail_index = fidx_q;

    // Sink ready: throttled by the rotating pattern while checking, always absorbing once done
    always_comb begin
        umi_in_ready = 1'b0;
        case (state_q)
            ST_RUN:  umi_in_ready = pat_q[0];
            ST_DONE: umi_in_ready = 1'b1;
            default: umi_in_ready = 1'b0;
        endcase
    end

    // Packet comparison: header in full, payload only on bytes covered by the expected command
    always_comb begin
        for (int i = 0; i < DW; i++) begin
            bit_mask[i] = byte_mask[i/8];
        end
        match = (umi_in_cmd == exp_cmd) &&
                (umi_in_dstaddr == exp_dst) &&
                (umi_in_srcaddr == exp_src) &&
                (nocompare || (((umi_in_data ^ exp_data) & bit_mask) == '0));
    end

    // Expected-packet storage; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (load_write) begin
            mem[wptr_q[PW-1:0]] <= load_packet;
        end
    end

    // Next-state: load pointer, FSM, pattern rotation, scoring
    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        pat_d   = pat_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        fidx_d  = fidx_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (load_write) begin
                    wptr_d = wptr_q + PTR_ONE;
                end
                if (go) begin
                    pat_d   = ready_pattern;
                    state_d = (wptr_q == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                pat_d = {pat_q[0], pat_q[7:1]};
                if (hs) begin
                    rptr_d = rptr_q + PTR_ONE;
                    if (match) begin
                        pass_d = (pass_q == 32'hFFFF_FFFF) ? pass_q : pass_q + 32'd1;
                    end else begin
                        fail_d = (fail_q == 32'hFFFF_FFFF) ? fail_q : fail_q + 32'd1;
                        err_d  = 1'b1;
                        if (fail_q == 32'd0) begin
                            fidx_d = rptr_q[PW-1:0];
                        end
                    end
                    if (rptr_q == wptr_q - PTR_ONE) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (hs) begin
                    err_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            pat_q   <= '0;
            pass_q  <= '0;
            fail_q  <= '0;
            fidx_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            pat_q   <= pat_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            fidx_q  <= fidx_d;
            err_q   <= err_d;
        end
    end

endmodule
